// File: rtl/axi_stream_slave_monitor.sv
// Passive AXI4-Stream slave-port monitor: traffic counters plus sticky protocol error flags.
// Define AXIS_SLAVE_MONITOR_STALL_LIMIT_EN to build the stall counter that drives err[3].
module axi_stream_slave_monitor #(
    parameter int byte_width  = 4,
    parameter int id_width    = 0,
    parameter int dest_width  = 0,
    parameter int user_width  = 0,
    parameter int count_width = 32,
    parameter int max_stall   = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  tvalid,
    input  logic                                  tready,
    input  logic [8*byte_width-1:0]               tdata,
    input  logic [byte_width-1:0]                 tstrb,
    input  logic [byte_width-1:0]                 tkeep,
    input  logic                                  tlast,
    input  logic [((id_width > 0) ? id_width : 1)-1:0]     tid,
    input  logic [((dest_width > 0) ? dest_width : 1)-1:0] tdest,
    input  logic [((user_width > 0) ? user_width : 1)-1:0] tuser,
    output logic [count_width-1:0]                beat_count,
    output logic [count_width-1:0]                byte_count,
    output logic [count_width-1:0]                packet_count,
    output logic [count_width-1:0]                pkt_beats,
    output logic                                  in_packet,
    output logic [3:0]                            err
);
    localparam int DW = 8 * byte_width;
    localparam int IW = (id_width > 0) ? id_width : 1;
    localparam int TW = (dest_width > 0) ? dest_width : 1;
    localparam int UW = (user_width > 0) ? user_width : 1;

    function automatic logic [count_width-1:0] sat_add(input logic [count_width-1:0] a,
                                                       input logic [count_width-1:0] b);
        logic [count_width:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[count_width] ? '1 : s[count_width-1:0];
    endfunction

    function automatic logic [count_width-1:0] popcount(input logic [byte_width-1:0] m);
        logic [count_width-1:0] n;
        n = '0;
        for (int i = 0; i < byte_width; i++) n = n + count_width'(m[i]);
        return n;
    endfunction

    logic [count_width-1:0] beat_q, beat_d, byte_q, byte_d, pkt_q, pkt_d, pb_q, pb_d;
    logic                   inp_q, inp_d;
    logic [3:0]             err_q, err_d, viol;
    logic                   stall_q;
    logic [DW-1:0]          tdata_q;
    logic [byte_width-1:0]  tstrb_q, tkeep_q;
    logic                   tlast_q;
    logic [IW-1:0]          tid_q;
    logic [TW-1:0]          tdest_q;
    logic [UW-1:0]          tuser_q;
    logic                   hs, stall, payload_chg;

    assign hs    = tvalid && tready;
    assign stall = tvalid && !tready;

    // Disabled sideband fields are excluded so their unconnected inputs cannot flag errors.
    assign payload_chg = (tdata != tdata_q) || (tstrb != tstrb_q) || (tkeep != tkeep_q) ||
                         (tlast != tlast_q) ||
                         ((id_width > 0) && (tid != tid_q)) ||
                         ((dest_width > 0) && (tdest != tdest_q)) ||
                         ((user_width > 0) && (tuser != tuser_q));

`ifdef AXIS_SLAVE_MONITOR_STALL_LIMIT_EN
    localparam int SW = $clog2(max_stall + 1) + 1;
    logic [SW-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = '0;
        if (stall) stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + SW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign viol[3] = (stall_cnt_q >= SW'(max_stall));
`else
    assign viol[3] = 1'b0;
`endif

    // stall_q is cleared by reset, so the stability checks stay disarmed for the first cycle.
    assign viol[0] = stall_q && !tvalid;
    assign viol[1] = stall_q && payload_chg;
    assign viol[2] = tvalid && |(tstrb & ~tkeep);

    always_comb begin
        beat_d = beat_q;
        byte_d = byte_q;
        pkt_d  = pkt_q;
        pb_d   = pb_q;
        inp_d  = inp_q;
        err_d  = err_q | viol;
        if (hs) begin
            beat_d = sat_add(beat_q, count_width'(1));
            byte_d = sat_add(byte_q, popcount(tkeep));
            if (tlast) begin
                pkt_d = sat_add(pkt_q, count_width'(1));
                pb_d  = '0;
                inp_d = 1'b0;
            end else begin
                pb_d  = sat_add(pb_q, count_width'(1));
                inp_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_q  <= '0;
            byte_q  <= '0;
            pkt_q   <= '0;
            pb_q    <= '0;
            inp_q   <= 1'b0;
            err_q   <= '0;
            stall_q <= 1'b0;
            tdata_q <= '0;
            tstrb_q <= '0;
            tkeep_q <= '0;
            tlast_q <= 1'b0;
            tid_q   <= '0;
            tdest_q <= '0;
            tuser_q <= '0;
        end else begin
            beat_q  <= beat_d;
            byte_q  <= byte_d;
            pkt_q   <= pkt_d;
            pb_q    <= pb_d;
            inp_q   <= inp_d;
            err_q   <= err_d;
            stall_q <= stall;
            tdata_q <= tdata;
            tstrb_q <= tstrb;
            tkeep_q <= tkeep;
            tlast_q <= tlast;
            tid_q   <= tid;
            tdest_q <= tdest;
            tuser_q <= tuser;
        end
    end

`ifdef FORMAL
    // Master-side rules are environment assumptions; only the stall limit is a design obligation.
    always_comb begin
        if (reset) begin
            assume (!tvalid);
        end else begin
            assume (!viol[0]);
            assume (!viol[1]);
            assume (!viol[2]);
`ifdef AXIS_SLAVE_MONITOR_STALL_LIMIT_EN
            assert (!viol[3]);
`endif
        end
    end
`endif

    assign beat_count   = beat_q;
    assign byte_count   = byte_q;
    assign packet_count = pkt_q;
    assign pkt_beats    = pb_q;
    assign in_packet    = inp_q;
    assign err          = err_q;
endmodule

// File: tb/tb_axi_stream_slave_monitor.sv
// Directed bench for axi_stream_slave_monitor: clean-traffic vector table plus error and reset sequences.
module tb_axi_stream_slave_monitor;
    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        tvalid, tready, tlast;
    logic [31:0] tdata;
    logic [3:0]  tstrb, tkeep;
    logic [0:0]  tid, tdest, tuser;
    logic [CW-1:0] beat_count, byte_count, packet_count, pkt_beats;
    logic        in_packet;
    logic [3:0]  err;

    int checks = 0;
    int errors = 0;

    axi_stream_slave_monitor #(
        .byte_width(4), .id_width(0), .dest_width(0), .user_width(0),
        .count_width(CW), .max_stall(4)
    ) dut (
        .clk(clk), .reset(reset), .tvalid(tvalid), .tready(tready), .tdata(tdata),
        .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast), .tid(tid), .tdest(tdest),
        .tuser(tuser), .beat_count(beat_count), .byte_count(byte_count),
        .packet_count(packet_count), .pkt_beats(pkt_beats), .in_packet(in_packet),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, r;
        logic [31:0] data;
        logic [3:0]  strb, keep;
        logic        last;
        logic [3:0]  eb, ey, ep, epb;
        logic        einp;
        logic [3:0]  eerr;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {11'b0, beat_count, byte_count, packet_count, pkt_beats, in_packet, err};
    endfunction

    task automatic drive(input logic v, input logic r, input logic [31:0] d,
                         input logic [3:0] s, input logic [3:0] k, input logic l);
        tvalid = v; tready = r; tdata = d; tstrb = s; tkeep = k; tlast = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);
        reset = 1'b1;
        tick();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        tid = '0; tdest = '0; tuser = '0;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0);
        reset = 1'b1;
        #1;
        check("reset_state", outs(), 32'h0);

        // byte_count saturates at 15 with count_width=4
        tbl[0]  = '{1'b1, 1'b1, 32'h11111111, 4'hF, 4'hF, 1'b0, 4'd1, 4'd4,  4'd0, 4'd1, 1'b1, 4'h0};
        tbl[1]  = '{1'b1, 1'b1, 32'h22222222, 4'hF, 4'hF, 1'b0, 4'd2, 4'd8,  4'd0, 4'd2, 1'b1, 4'h0};
        tbl[2]  = '{1'b1, 1'b1, 32'h33333333, 4'h3, 4'h3, 1'b1, 4'd3, 4'd10, 4'd1, 4'd0, 1'b0, 4'h0};
        tbl[3]  = '{1'b0, 1'b1, 32'h0,        4'h0, 4'h0, 1'b0, 4'd3, 4'd10, 4'd1, 4'd0, 1'b0, 4'h0};
        tbl[4]  = '{1'b1, 1'b0, 32'hCAFEF00D, 4'hF, 4'hF, 1'b1, 4'd3, 4'd10, 4'd1, 4'd0, 1'b0, 4'h0};
        tbl[5]  = '{1'b1, 1'b1, 32'hCAFEF00D, 4'hF, 4'hF, 1'b1, 4'd4, 4'd14, 4'd2, 4'd0, 1'b0, 4'h0};
        tbl[6]  = '{1'b1, 1'b1, 32'h000000AB, 4'h1, 4'h1, 1'b1, 4'd5, 4'd15, 4'd3, 4'd0, 1'b0, 4'h0};
        tbl[7]  = '{1'b1, 1'b0, 32'h00DDDDDD, 4'h7, 4'h7, 1'b0, 4'd5, 4'd15, 4'd3, 4'd0, 1'b0, 4'h0};
        tbl[8]  = '{1'b1, 1'b1, 32'h00DDDDDD, 4'h7, 4'h7, 1'b0, 4'd6, 4'd15, 4'd3, 4'd1, 1'b1, 4'h0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,        4'h0, 4'h0, 1'b0, 4'd6, 4'd15, 4'd3, 4'd1, 1'b1, 4'h0};
        tbl[10] = '{1'b1, 1'b1, 32'h12345678, 4'h0, 4'h0, 1'b1, 4'd7, 4'd15, 4'd4, 4'd0, 1'b0, 4'h0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,        4'h0, 4'h0, 1'b0, 4'd7, 4'd15, 4'd4, 4'd0, 1'b0, 4'h0};

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, tbl[i].r, tbl[i].data, tbl[i].strb, tbl[i].keep, tbl[i].last);
            tick();
            check($sformatf("vec%0d", i), outs(),
                  {11'b0, tbl[i].eb, tbl[i].ey, tbl[i].ep, tbl[i].epb, tbl[i].einp, tbl[i].eerr});
        end

        // Reset pulse in the middle of an open packet
        do_reset();
        drive(1'b1, 1'b1, 32'h1, 4'hF, 4'hF, 1'b0);
        tick();
        tick();
        check("pre_reset_open", outs(), {11'b0, 4'd2, 4'd8, 4'd0, 4'd2, 1'b1, 4'h0});
        reset = 1'b1;
        #1;
        check("async_reset_clears", outs(), 32'h0);
        drive(1'b0, 1'b1, 32'h0, 4'h0, 4'h0, 1'b0);
        tick();
        tready = 1'b0;
        tick();
        check("held_in_reset", outs(), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("post_reset_in_packet", {31'b0, in_packet}, 32'h0);
        check("post_reset_pkt_beats", {28'b0, pkt_beats}, 32'h0);

        // Payload change while stalled
        do_reset();
        drive(1'b1, 1'b0, 32'hA5A5A5A5, 4'hF, 4'hF, 1'b0);
        tick();
        check("stall_no_err_yet", {28'b0, err}, 32'h0);
        tdata = 32'h0;
        tick();
        check("stall_change_err1", {28'b0, err}, 32'h2);
        check("stall_change_counts", {20'b0, beat_count, byte_count, packet_count}, 32'h0);

        // tvalid withdrawn without a handshake
        do_reset();
        drive(1'b1, 1'b0, 32'h5, 4'hF, 4'hF, 1'b0);
        tick();
        tvalid = 1'b0;
        tick();
        check("valid_drop_err0", {28'b0, err}, 32'h1);
        check("valid_drop_beats", {28'b0, beat_count}, 32'h0);

        // tstrb asserted on a null byte
        do_reset();
        drive(1'b1, 1'b1, 32'h7, 4'h7, 4'h3, 1'b1);
        tick();
        check("strb_keep_err2", {28'b0, err}, 32'h4);

        // Five stall cycles against max_stall=4
        do_reset();
        drive(1'b1, 1'b0, 32'h9, 4'hF, 4'hF, 1'b0);
        for (int i = 0; i < 5; i++) tick();
`ifdef AXIS_SLAVE_MONITOR_STALL_LIMIT_EN
        check("stall_limit_err3", {28'b0, err}, 32'h8);
`else
        check("stall_limit_err3", {28'b0, err}, 32'h0);
`endif
        check("stall_limit_beats", {28'b0, beat_count}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
